// File: rtl/mod_inv_check.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mod_inv_check - bit-serial MSB-first (a*r) mod p; ok flags a product of 1.
// Optional input range check: `MOD_INV_CHECK_RANGE_EN.          Rev 1.0
// ----------------------------------------------------------------------------
module mod_inv_check #(
  parameter int K = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [K-1:0] a,
  input  logic [K-1:0] r,
  input  logic [K-1:0] p,
  output logic [K-1:0] prod,
  output logic         ok,
  output logic         err,
  output logic         valid_out,
  output logic         busy
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [K-1:0]  acc;
  logic [K-1:0]  a_q;
  logic [K-1:0]  r_q;
  logic [K-1:0]  p_q;
  logic [CW-1:0] cnt;

  logic [K:0] dbl;
  logic [K:0] t;
  logic [K:0] sum;
  logic [K:0] u;

  // acc < p_q keeps both doubling and addition below 2*p_q, so one
  // conditional subtract per half-step restores the invariant.
  always_comb begin
    dbl = {acc, 1'b0};
    t   = (dbl >= {1'b0, p_q}) ? dbl - {1'b0, p_q} : dbl;
    sum = t + (r_q[cnt] ? {1'b0, a_q} : {(K+1){1'b0}});
    u   = (sum >= {1'b0, p_q}) ? sum - {1'b0, p_q} : sum;
  end

`ifdef MOD_INV_CHECK_RANGE_EN
  logic bad_in;
  assign bad_in = (a >= p) || (r >= p) || (p < K'(2));
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      prod      <= '0;
      ok        <= 1'b0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      a_q       <= '0;
      r_q       <= '0;
      p_q       <= '0;
`ifdef MOD_INV_CHECK_RANGE_EN
      err       <= 1'b0;
`endif
    end else begin
      valid_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_in) begin
            a_q  <= a;
            r_q  <= r;
            p_q  <= p;
            acc  <= '0;
            cnt  <= CW'(K - 1);
            busy <= 1'b1;
`ifdef MOD_INV_CHECK_RANGE_EN
            err  <= bad_in;
            if (bad_in) begin
              prod      <= '0;
              ok        <= 1'b0;
              valid_out <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_RUN;
            end
`else
            state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          acc <= u[K-1:0];
          if (cnt == '0) begin
            prod      <= u[K-1:0];
            ok        <= (u == {{K{1'b0}}, 1'b1});
            valid_out <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
